regfile_write_arbiter: RTL

//  Shares the register file's single write port among NREQ requesters (e.g. ALU

---
 rtl/regfile_write_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : regfile_write_arbiter
// Purpose : Round-robin arbiter for the register file's single write port,
//           with a clear sweep that zeroes registers 1..NREGS-1.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          grant,
    input  logic                     clear_req,
    output logic [NREGS-1:0]         reg_we,
    output logic [DATA_W-1:0]        reg_wdata,
    output logic                     busy,
    output logic                     clear_done
);

    localparam int c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [0:0]          c_idle  = 1'b0;
    localparam logic [0:0]          c_sweep = 1'b1;
    localparam logic [c_ptr_w:0]    c_nreq  = (c_ptr_w+1)'(NREQ);
    localparam logic [c_ptr_w-1:0]  c_ptr_rst = c_ptr_w'(NREQ - 1);
    localparam logic [ADDR_W-1:0]   c_first = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]   c_last  = ADDR_W'(NREGS - 1);
    localparam logic [NREGS-1:0]    c_one   = NREGS'(1);

    logic [0:0]          r_state;
    logic [c_ptr_w-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0]   r_cnt;
    logic [NREGS-1:0]    r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done;

    logic [ADDR_W-1:0]   w_addr [NREQ];
    logic [DATA_W-1:0]   w_data [NREQ];
    logic [c_ptr_w:0]    w_idx;
    logic [c_ptr_w-1:0]  w_winner;
    logic                w_found;
    logic                w_grant_ok;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NREGS-1:0]    w_we_req;
    logic [NREGS-1:0]    w_we_sweep;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_data[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (c_ptr_w+1)'(k);
            if (w_idx >= c_nreq) begin
                w_idx = w_idx - c_nreq;
            end
            if (!w_found && req[w_idx[c_ptr_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_ptr_w-1:0];
            end
        end
    end

    assign w_grant_ok = !reset && (r_state == c_idle) && !clear_req && w_found;
    assign grant      = w_grant_ok ? (NREQ'(1) << w_winner) : '0;
    assign w_sel_addr = w_addr[w_winner];
    assign w_sel_data = w_data[w_winner];
    // Register 0 is hard-wired zero, so a write to it is simply dropped.
    assign w_we_req   = (w_sel_addr == '0) ? '0 : (c_one << w_sel_addr);
    assign w_we_sweep = c_one << r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_idle;
            r_rr_ptr <= c_ptr_rst;
            r_cnt    <= c_first;
            r_we     <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    r_done <= 1'b0;
                    if (clear_req) begin
                        r_state <= c_sweep;
                        r_cnt   <= c_first;
                        r_we    <= '0;
                    end else if (w_grant_ok) begin
                        r_we     <= w_we_req;
                        r_wdata  <= w_sel_data;
                        r_rr_ptr <= w_winner;
                    end else begin
                        r_we <= '0;
                    end
                end
                c_sweep: begin
                    r_we    <= w_we_sweep;
                    r_wdata <= '0;
                    if (r_cnt == c_last) begin
                        r_state <= c_idle;
                        r_cnt   <= c_first;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + c_first;
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_we    <= '0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_we     = r_we;
    assign reg_wdata  = r_wdata;
    assign busy       = (r_state == c_sweep);
    assign clear_done = r_done;

endmodule
`default_nettype wire
